mem_port_arbiter: RTL and testbench

- Shares one single-port memory between the MIPS core's instruction-fetch port (I) and load/store port (D).
- Arbitrates on contention, sequences each memory transaction with a req/ready handshake, and returns read data with a one-cycle ack.
- Drives cpu_stall so the core freezes its PC and register writeback while either port is waiting.
- A wait-state watchdog prevents a dead memory from hanging the core.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter and its environment: the MIPS core's
// fetch (i_*) and load/store (d_*) ports, the single-port memory (mem_*), and
// the status outputs cpu_stall and err_timeout.
// Modports: master = the arbiter itself; slave = core plus memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  // Load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  // Memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  // Status
  logic              cpu_stall;
  logic              err_timeout;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           cpu_stall, err_timeout
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           cpu_stall, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core's fetch (I) and load/store (D) ports.
// Latency: request sampled in IDLE -> mem_req next cycle -> ack the cycle after
// mem_ready (or after the MAX_WAIT watchdog fires); minimum 3 cycles per transaction.
// Backpressure: requesters hold req until their one-cycle ack; cpu_stall is high
// while either port waits. Ports: clk, rst (async active-high), bus (master modport).
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ACK} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;        // 1: last contended grant went to D
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_timeout_q, err_timeout_d;
  logic              take_i, take_d;

  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    wait_cnt_d    = wait_cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    i_ack_d       = i_ack_q;
    d_ack_d       = d_ack_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    err_timeout_d = err_timeout_q;
    take_i        = 1'b0;
    take_d        = 1'b0;

    case (state_q)
      IDLE: begin
        // Round-robin only matters on contention; uncontended grants leave
        // the history untouched.
        if (bus.i_req && bus.d_req) begin
          take_d   = !last_d_q;
          take_i   = last_d_q;
          last_d_d = !last_d_q;
        end else begin
          take_i = bus.i_req;
          take_d = bus.d_req;
        end
        if (take_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          wait_cnt_d  = 8'd0;
        end else if (take_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = '0;
          wait_cnt_d  = 8'd0;
        end
      end

      BUSY_I, BUSY_D: begin
        // A late mem_ready on the watchdog's last cycle still wins.
        if (bus.mem_ready) begin
          if (state_q == BUSY_I) begin
            i_rdata_d = bus.mem_rdata;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = bus.mem_rdata;
            d_ack_d   = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = ACK;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          if (state_q == BUSY_I) begin
            i_rdata_d = '1;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = '1;
            d_ack_d   = 1'b1;
          end
          err_timeout_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = ACK;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ACK: begin
        // No arbitration here, so the requester's still-high req is not regranted.
        i_ack_d       = 1'b0;
        d_ack_d       = 1'b0;
        err_timeout_d = 1'b0;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b0;
      wait_cnt_q    <= 8'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_ack       = i_ack_q;
  assign bus.d_ack       = d_ack_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.cpu_stall   = (bus.i_req & ~i_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory device and reference contents ----------------
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] ref_m [logic [31:0]];
  int          wait_q[$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : init_word(a);
  endfunction

  // Memory answers after a planned number of wait cycles per burst; junk on
  // mem_ready/mem_rdata whenever no request is outstanding.
  initial begin
    bit in_burst;
    int cnt, w;
    in_burst      = 1'b0;
    cnt           = 0;
    w             = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          cnt      = 0;
          w        = (wait_q.size() > 0) ? wait_q.pop_front() : 1000;
        end
        cnt++;
        if (cnt == w + 1) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = bus.mem_we ? $urandom : mem_rd(bus.mem_addr);
          if (bus.mem_we) mem_m[bus.mem_addr] = bus.mem_wdata;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        in_burst      = 1'b0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          w;      // planned memory wait cycles
    int          s;      // first cycle of mem_req
    int          b;      // cycles mem_req stays high
    int          a;      // ack cycle
    bit          to;     // watchdog expected to fire
    logic [31:0] exp_rd;
  } txn_t;

  txn_t tq[$];          // transactions in expected service order
  bit   last_d = 1'b0;  // last contended grant went to D

  // Called at a negedge; cycle 0 is the cycle in which requests are driven.
  // b2b: all entries are fetches on I, next address presented in each ACK cycle.
  task automatic run_txns(input bit b2b);
    int s;
    int last;
    bit e_req, e_iack, e_dack, e_err;
    int kreq;
    s = 1;
    foreach (tq[k]) begin
      tq[k].to = (tq[k].w > MAXW);
      tq[k].b  = tq[k].to ? MAXW + 1 : tq[k].w + 1;
      tq[k].s  = s;
      tq[k].a  = s + tq[k].b;
      s        = tq[k].a + 2;
      tq[k].exp_rd = tq[k].to ? 32'hFFFF_FFFF : (tq[k].we ? 32'h0 : ref_rd(tq[k].addr));
      if (tq[k].we && !tq[k].to) ref_m[tq[k].addr] = tq[k].wdata;
      wait_q.push_back(tq[k].w);
    end
    foreach (tq[k]) begin
      if (!b2b || k == 0) begin
        if (tq[k].is_d) begin
          bus.d_req = 1'b1; bus.d_we = tq[k].we;
          bus.d_addr = tq[k].addr; bus.d_wdata = tq[k].wdata;
        end else begin
          bus.i_req = 1'b1; bus.i_addr = tq[k].addr;
        end
      end
    end
    #1 chk("stall_c0", 32'(bus.cpu_stall), 32'd1);
    last = tq[tq.size()-1].a;
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      e_req = 0; e_iack = 0; e_dack = 0; e_err = 0; kreq = -1;
      foreach (tq[k]) begin
        if (c >= tq[k].s && c < tq[k].s + tq[k].b) kreq = k;
        if (c == tq[k].a) begin
          if (tq[k].is_d) e_dack = 1; else e_iack = 1;
          e_err = tq[k].to;
        end
      end
      e_req = (kreq >= 0);
      chk("mem_req", 32'(bus.mem_req), 32'(e_req));
      if (kreq >= 0) begin
        chk("mem_addr",  bus.mem_addr, tq[kreq].addr);
        chk("mem_we",    32'(bus.mem_we), 32'(tq[kreq].we));
        chk("mem_wdata", bus.mem_wdata, tq[kreq].is_d ? tq[kreq].wdata : 32'h0);
      end
      chk("i_ack", 32'(bus.i_ack), 32'(e_iack));
      chk("d_ack", 32'(bus.d_ack), 32'(e_dack));
      chk("err_timeout", 32'(bus.err_timeout), 32'(e_err));
      foreach (tq[k]) begin
        if ((c == tq[k].a || c == tq[k].a + 1) && !tq[k].we) begin
          if (tq[k].is_d) chk("d_rdata", bus.d_rdata, tq[k].exp_rd);
          else            chk("i_rdata", bus.i_rdata, tq[k].exp_rd);
        end
      end
      chk("cpu_stall", 32'(bus.cpu_stall),
          32'((bus.i_req & ~e_iack) | (bus.d_req & ~e_dack)));
      foreach (tq[k]) begin
        if (c == tq[k].a) begin
          if (b2b && k + 1 < tq.size()) bus.i_addr = tq[k+1].addr;
          else if (tq[k].is_d)          bus.d_req = 1'b0;
          else                          bus.i_req = 1'b0;
        end
      end
    end
  endtask

  task automatic pair(input bit ri, input bit rd, input bit dwe,
                      input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] dwd, input int wi, input int wd);
    txn_t ti, td;
    ti = '{is_d: 0, we: 0, addr: ia, wdata: 32'h0, w: wi,
           s: 0, b: 0, a: 0, to: 0, exp_rd: 32'h0};
    td = '{is_d: 1, we: dwe, addr: da, wdata: dwd, w: wd,
           s: 0, b: 0, a: 0, to: 0, exp_rd: 32'h0};
    tq.delete();
    if (ri && rd) begin
      if (last_d) begin tq.push_back(ti); tq.push_back(td); end
      else        begin tq.push_back(td); tq.push_back(ti); end
      last_d = !last_d;
    end else if (ri) tq.push_back(ti);
    else             tq.push_back(td);
    run_txns(1'b0);
  endtask

  function automatic logic [31:0] rnd_addr();
    return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  function automatic int rnd_wait();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    txn_t t;
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req",   32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'd0);
    chk("rst_i_ack",     32'(bus.i_ack), 32'd0);
    chk("rst_d_ack",     32'(bus.d_ack), 32'd0);
    chk("rst_i_rdata",   bus.i_rdata, 32'd0);
    chk("rst_err",       32'(bus.err_timeout), 32'd0);
    chk("rst_stall",     32'(bus.cpu_stall), 32'd0);
    rst = 1'b0;

    // Single fetch with known memory word
    mem_m[32'h40] = 32'h2010_0005;
    ref_m[32'h40] = 32'h2010_0005;
    pair(1, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 0, 0);

    // Contention: D first, then I; second pair goes I first
    pair(1, 1, 0, rnd_addr(), 32'h0000_0100, 32'h0, 0, 0);
    pair(1, 1, 0, rnd_addr(), 32'h0000_0100, 32'h0, 1, 2);

    // Store with 3 wait cycles, then read it back
    pair(0, 1, 1, 32'h0, 32'h0000_0200, 32'hDEAD_BEEF, 0, 3);
    pair(0, 1, 0, 32'h0, 32'h0000_0200, 32'h0, 0, 0);

    // Watchdog: never ready, exactly-at-limit ready, one past the limit
    pair(1, 0, 0, rnd_addr(), 32'h0, 32'h0, 20, 0);
    pair(1, 0, 0, rnd_addr(), 32'h0, 32'h0, MAXW, 0);
    pair(0, 1, 0, 32'h0, rnd_addr(), 32'h0, 0, MAXW + 1);

    // Reset while D is busy: everything clears at once, no d_ack
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0300; bus.d_wdata = 32'h1234_5678;
    wait_q.push_back(10);
    repeat (3) @(negedge clk);
    chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_mem_req",   32'(bus.mem_req), 32'd0);
    chk("arst_mem_we",    32'(bus.mem_we), 32'd0);
    chk("arst_mem_addr",  bus.mem_addr, 32'd0);
    chk("arst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("arst_i_rdata",   bus.i_rdata, 32'd0);
    chk("arst_d_rdata",   bus.d_rdata, 32'd0);
    chk("arst_err",       32'(bus.err_timeout), 32'd0);
    chk("arst_stall",     32'(bus.cpu_stall), 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("arst_d_ack", 32'(bus.d_ack), 32'd0);
      chk("arst_i_ack", 32'(bus.i_ack), 32'd0);
    end
    rst    = 1'b0;
    last_d = 1'b0;
    pair(0, 1, 0, 32'h0, 32'h0000_0300, 32'h1234_5678, 0, 1);

    // Back-to-back fetches with address changed in each ACK cycle
    tq.delete();
    for (int k = 0; k < 4; k++) begin
      t = '{is_d: 0, we: 0, addr: rnd_addr(), wdata: 32'h0, w: int'($urandom_range(0, 2)),
            s: 0, b: 0, a: 0, to: 0, exp_rd: 32'h0};
      tq.push_back(t);
    end
    run_txns(1'b1);

    // Randomized mix
    repeat (40) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      pair(sel[0], sel[1], 1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(),
           $urandom, rnd_wait(), rnd_wait());
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
